clk_div_multi: RTL and testbench
================================

# clk_div_multi

Multi-channel programmable clock divider generating NUM_CH independent divided clocks and per-channel single-cycle tick strobes from the 50 MHz system clock. Each channel has a run-time divide ratio written through a simple config port. Ratio changes and enable/disable take effect only at period boundaries, so no runt pulses occur. It sits beside the core clocking logic and feeds peripheral/timebase logic, which should prefer tick over out_clk as a clock enable.

## Interface
- NUM_CH, 4: number of independent channels (1..16)
- CNT_W, 26: counter/ratio width; max ratio 2^CNT_W-1
- DEFAULT_DIV, 50: ratio loaded at reset into every channel (50 MHz -> 1 MHz)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  NUM_CH  per-channel run enable, level, sampled every clk
- cfg_we  in  1  config write strobe, one write per asserted cycle
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel; values >= NUM_CH ignored
- cfg_div  in  CNT_W  new divide ratio N
- out_clk  out  NUM_CH  divided clocks, registered
- tick  out  NUM_CH  one-clk pulse coincident with each out_clk rising edge
- div_pend  out  NUM_CH  shadow ratio written but not yet applied

## Operation
- Reset: all outputs 0; per channel cnt=0, state IDLE, active ratio = shadow ratio = DEFAULT_DIV (DEFAULT_DIV <2 treated as 2), div_pend=0.
- Ratio rules: cfg_div <2 stored as 2. HI = N>>1 (high cycles); low cycles = N-HI. Odd N: low phase one cycle longer.
- States per channel: IDLE, RUN, STOP.
- IDLE: cnt=0, out_clk=0, tick=0. en=1 -> RUN (cnt stays 0 on that edge). Pending shadow applied immediately on any IDLE edge; div_pend clears.
- RUN/STOP counting, each edge:
  - cnt==N-1 (boundary): cnt<=0; active ratio <= shadow, div_pend<=0 (only if pending). RUN: out_clk<=1, tick<=1. STOP: go IDLE, out_clk stays 0, no tick.
  - cnt==HI-1 and not boundary: out_clk<=0, cnt+1.
  - otherwise cnt+1, tick<=0.
- RUN with en=0 -> STOP; counting continues so the current period completes (out falls normally at HI-1). STOP with en=1 -> RUN, no disturbance of cnt/out.
- Config write: cfg_we=1, cfg_ch valid -> shadow[cfg_ch]<=clamp(cfg_div), div_pend[cfg_ch]<=1. Write on the same edge as a boundary: boundary uses the previously stored shadow; new value remains pending until the next boundary. Back-to-back writes: last one wins.
- Comparisons use active ratio only; counter never exceeds N-1 and wraps only at the boundary.

## Timing
- Enable latency: en sampled high in IDLE at edge E0 -> first out_clk rise and tick at edge E0+N.
- Steady state: out_clk period exactly N clks, high HI clks; tick period N, width 1, asserted in the same cycle out_clk goes high.
- Ratio change latency: applied at the first boundary after the write (<= N_old clks); the first new-ratio period starts on that edge.
- Disable latency: out_clk stays low and channel reaches IDLE at the current period's boundary; no extra tick after en falls, except one already due on the edge where en is first sampled low (RUN->STOP transition takes effect that edge; the boundary check uses the state before the edge).
- Async reset mid-period: all outputs 0 immediately; no pending write survives.
- Channels are fully independent; simultaneous config write and boundary on different channels do not interact.

## Test plan
- Reset, en[0]=1 at edge 0, N=50 -> tick[0] at edges 50,100,150; out_clk[0] high 25 clks, low 25 clks.
- Write cfg_ch=1, cfg_div=3, then en[1]=1 -> period 3, high 1, low 2; div_pend[1] clears while IDLE, before enable.
- Channel 0 running at N=10; write N=4 at cnt=3 -> div_pend[0]=1 until edge with cnt==9, then period 4 from there; no runt pulse.
- Drop en[2] during high phase (N=8, cnt=2) -> out falls at cnt==3, IDLE at boundary, no further ticks; re-raise en during STOP -> uninterrupted period-8 output.
- cfg_div=0 and 1 -> behaves as N=2 (alternate high/low each clk, tick every 2 clks); cfg_ch=NUM_CH write -> no channel affected.
- Assert rst low mid-period on all channels -> out_clk, tick, div_pend all 0 asynchronously; after release ratios back to DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable clock dividers.
// Every channel produces a registered divided clock plus a one-cycle tick that
// coincides with each rising edge of that clock. Ratio updates and
// enable/disable only take effect on period boundaries, so the output never
// has a runt pulse.

// One divider channel: the run/stop state machine, the counter, and the
// active and shadow ratio registers.
module clk_div_ch #(
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] div,
  output logic             out_clk,
  output logic             tick,
  output logic             div_pend
);

  // A ratio below 2 has no room for both a high and a low phase, so it
  // is raised to 2.
  localparam int               DEF_I = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
  localparam logic [CNT_W-1:0] DEF   = CNT_W'(DEF_I);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt, act, shd;
  logic [CNT_W-1:0] div_c, hi_m1, nm1;
  logic             bnd, apply;

  assign div_c = (div < CNT_W'(2)) ? CNT_W'(2) : div;
  // The high phase lasts N>>1 cycles. For odd N the extra cycle goes to the
  // low phase.
  assign hi_m1 = (act >> 1) - CNT_W'(1);
  assign nm1   = act - CNT_W'(1);
  // Boundary detection uses the state from before this edge.
  assign bnd   = (st != IDLE) && (cnt == nm1);
  // A pending shadow ratio can be promoted on any IDLE edge or at a period
  // boundary.
  assign apply = (st == IDLE) || bnd;

  // Channel state machine, counter, ratio registers, and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= IDLE;
      cnt      <= '0;
      act      <= DEF;
      shd      <= DEF;
      div_pend <= 1'b0;
      out_clk  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (st)
        IDLE: begin
          cnt     <= '0;
          out_clk <= 1'b0;
          if (en) st <= RUN;
        end
        default: begin
          if (bnd) begin
            cnt <= '0;
            if (st == RUN) begin
              out_clk <= 1'b1;
              tick    <= 1'b1;
            end else begin
              out_clk <= 1'b0;
              st      <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == hi_m1) out_clk <= 1'b0;
          end
          // The current period keeps counting in STOP, so the output falls
          // at its normal time. Resuming before the boundary leaves the
          // waveform unchanged.
          if (st == RUN && !en)             st <= STOP;
          else if (st == STOP && en && !bnd) st <= RUN;
        end
      endcase
      if (apply && div_pend) act <= shd;
      // A write on the same edge as a boundary does not take effect on that
      // edge. The new value stays pending until the next boundary.
      if (wr) begin
        shd      <= div_c;
        div_pend <= 1'b1;
      end else if (apply) begin
        div_pend <= 1'b0;
      end
    end
  end

endmodule

// Top level: decodes config writes and instantiates one channel per lane.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 50
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CH-1:0]                             en,
  input  logic                                          cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                              cfg_div,
  output logic [NUM_CH-1:0]                             out_clk,
  output logic [NUM_CH-1:0]                             tick,
  output logic [NUM_CH-1:0]                             div_pend
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    // An out-of-range cfg_ch matches no lane, so that write is dropped.
    assign wr = cfg_we && (int'(cfg_ch) == i);

    clk_div_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .wr       (wr),
      .div      (cfg_div),
      .out_clk  (out_clk[i]),
      .tick     (tick[i]),
      .div_pend (div_pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed testbench for clk_div_multi. It uses five channels so that a
// cfg_ch value outside the channel range can be represented on the 3-bit
// port.
module tb_clk_div_multi;

  localparam int NCH = 5;
  localparam int CW  = 26;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] en;
  logic           cfg_we;
  logic [2:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [NCH-1:0] out_clk, tick, div_pend;

  int checks   = 0;
  int failures = 0;

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(50)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .out_clk  (out_clk),
    .tick     (tick),
    .div_pend (div_pend)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one rising edge, then settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    step();
    rst = 1'b1;
  endtask

  task automatic cfg_write(input int ch, input int d);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_div = CW'(d);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    #35;
    checks++; if (out_clk !== '0) begin failures++; $display("FAIL reset_out got=%b exp=0", out_clk); end
    checks++; if (tick !== '0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (div_pend !== '0) begin failures++; $display("FAIL reset_pend got=%b exp=0", div_pend); end
    step();
    rst = 1'b1;
  endtask

  // N=50 from reset: tick on edges 50/100/150, 25 cycles high and 25 low.
  task automatic test_default();
    bit et, eo;
    do_reset();
    en[0] = 1'b1;
    for (int k = 0; k <= 150; k++) begin
      step();
      et = (k > 0) && (k % 50 == 0);
      eo = (k >= 50) && ((k - 50) % 50 < 25);
      checks++; if (tick[0] !== et) begin failures++; $display("FAIL default_tick k=%0d got=%b exp=%b", k, tick[0], et); end
      checks++; if (out_clk[0] !== eo) begin failures++; $display("FAIL default_out k=%0d got=%b exp=%b", k, out_clk[0], eo); end
    end
  endtask

  // N=3: 1 cycle high, 2 low. A pending write is applied while IDLE.
  task automatic test_small_div();
    bit e;
    do_reset();
    cfg_write(1, 3);
    checks++; if (div_pend[1] !== 1'b1) begin failures++; $display("FAIL small_pend_set got=%b exp=1", div_pend[1]); end
    step();
    checks++; if (div_pend[1] !== 1'b0) begin failures++; $display("FAIL small_pend_clr got=%b exp=0", div_pend[1]); end
    en[1] = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      e = (k > 0) && (k % 3 == 0);
      checks++; if (tick[1] !== e) begin failures++; $display("FAIL small_tick k=%0d got=%b exp=%b", k, tick[1], e); end
      checks++; if (out_clk[1] !== e) begin failures++; $display("FAIL small_out k=%0d got=%b exp=%b", k, out_clk[1], e); end
    end
  endtask

  // Running at N=10, N=4 is written on edge 14. It becomes active at the
  // boundary on edge 20.
  task automatic test_ratio_change();
    bit et, eo, ep;
    do_reset();
    cfg_write(0, 10);
    step();
    en[0] = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      step();
      et = (k > 0 && k <= 20 && k % 10 == 0) || (k > 20 && (k - 20) % 4 == 0);
      eo = (k >= 10 && k < 20 && k % 10 < 5) || (k >= 20 && (k - 20) % 4 < 2);
      ep = (k >= 14) && (k < 20);
      checks++; if (tick[0] !== et) begin failures++; $display("FAIL chg_tick k=%0d got=%b exp=%b", k, tick[0], et); end
      checks++; if (out_clk[0] !== eo) begin failures++; $display("FAIL chg_out k=%0d got=%b exp=%b", k, out_clk[0], eo); end
      checks++; if (div_pend[0] !== ep) begin failures++; $display("FAIL chg_pend k=%0d got=%b exp=%b", k, div_pend[0], ep); end
      if (k == 13) begin cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = CW'(4); end
      if (k == 14) cfg_we = 1'b0;
    end
  endtask

  // N=8. en drops while cnt=2 (sampled on edge 19). Optionally en is raised
  // again during STOP (sampled on edge 22).
  task automatic test_disable(input bit resume);
    bit et, eo;
    do_reset();
    cfg_write(2, 8);
    step();
    en[2] = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step();
      if (resume) begin
        et = (k > 0) && (k % 8 == 0);
        eo = (k >= 8) && (k % 8 < 4);
      end else begin
        et = (k == 8) || (k == 16);
        eo = (k >= 8) && (k < 20) && (k % 8 < 4);
      end
      checks++; if (tick[2] !== et) begin failures++; $display("FAIL dis%0d_tick k=%0d got=%b exp=%b", resume, k, tick[2], et); end
      checks++; if (out_clk[2] !== eo) begin failures++; $display("FAIL dis%0d_out k=%0d got=%b exp=%b", resume, k, out_clk[2], eo); end
      if (k == 18) en[2] = 1'b0;
      if (resume && k == 21) en[2] = 1'b1;
    end
  endtask

  // Writing 0 or 1 behaves as N=2. A write to cfg_ch=5 must not reach any
  // channel.
  task automatic test_min_div();
    bit e;
    do_reset();
    cfg_write(3, 0);
    cfg_write(4, 1);
    checks++; if (div_pend !== 5'b10000) begin failures++; $display("FAIL min_pend got=%b exp=10000", div_pend); end
    cfg_write(5, 7);
    checks++; if (div_pend !== 5'b00000) begin failures++; $display("FAIL bad_ch_pend got=%b exp=00000", div_pend); end
    en[3] = 1'b1; en[4] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      e = (k > 0) && (k % 2 == 0);
      checks++; if (tick[4:3] !== {e, e}) begin failures++; $display("FAIL min_tick k=%0d got=%b exp=%b%b", k, tick[4:3], e, e); end
      checks++; if (out_clk[4:3] !== {e, e}) begin failures++; $display("FAIL min_out k=%0d got=%b exp=%b%b", k, out_clk[4:3], e, e); end
    end
    checks++; if (out_clk[2:0] !== 3'b000) begin failures++; $display("FAIL min_others got=%b exp=000", out_clk[2:0]); end
  endtask

  // Asynchronous reset right after a boundary on which a write also
  // landed. Afterwards ch1 must be back at the default ratio.
  task automatic test_reset_mid();
    do_reset();
    en = '1;
    for (int k = 0; k <= 50; k++) begin
      step();
      if (k == 49) begin cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = CW'(7); end
    end
    cfg_we = 1'b0;
    checks++; if (tick !== 5'h1f) begin failures++; $display("FAIL pre_rst_tick got=%b exp=11111", tick); end
    checks++; if (out_clk !== 5'h1f) begin failures++; $display("FAIL pre_rst_out got=%b exp=11111", out_clk); end
    checks++; if (div_pend !== 5'b00010) begin failures++; $display("FAIL bnd_write_pend got=%b exp=00010", div_pend); end
    #3 rst = 1'b0;
    #1;
    checks++; if (out_clk !== '0) begin failures++; $display("FAIL async_out got=%b exp=0", out_clk); end
    checks++; if (tick !== '0) begin failures++; $display("FAIL async_tick got=%b exp=0", tick); end
    checks++; if (div_pend !== '0) begin failures++; $display("FAIL async_pend got=%b exp=0", div_pend); end
    en = '0;
    step();
    rst = 1'b1;
    en[1] = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      step();
      checks++; if (tick[1] !== (k == 50)) begin failures++; $display("FAIL post_rst_tick k=%0d got=%b exp=%b", k, tick[1], (k == 50)); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_small_div();
    test_ratio_change();
    test_disable(1'b0);
    test_disable(1'b1);
    test_min_div();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
